rename_map_table: RTL and testbench



---
 rtl/rename_map_table.sv | 181 ++++++++++++++++++
 tb/tb_rename_map_table.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map_table.sv
// Speculative/architectural register alias table: combinational rename reads with intra-group bypass, writes visible next cycle.
// A flush stalls rename (rn_ready low) for the flush cycle plus LREG_NUM/RESTORE_PER_CYCLE restore cycles.
module rename_map_table #(
    parameter int RENAME_WIDTH      = 2,
    parameter int COMMIT_WIDTH      = 2,
    parameter int LREG_NUM          = 32,
    parameter int PREG_WIDTH        = 6,
    parameter int RESTORE_PER_CYCLE = 8,
    localparam int LW               = $clog2(LREG_NUM)
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [RENAME_WIDTH-1:0]          rn_valid,
    input  logic [RENAME_WIDTH-1:0]          rn_src1_is_reg,
    input  logic [RENAME_WIDTH-1:0]          rn_src2_is_reg,
    input  logic [RENAME_WIDTH-1:0]          rn_need_to_wb,
    input  logic [RENAME_WIDTH*LW-1:0]       rn_lrs1,
    input  logic [RENAME_WIDTH*LW-1:0]       rn_lrs2,
    input  logic [RENAME_WIDTH*LW-1:0]       rn_lrd,
    input  logic [RENAME_WIDTH*PREG_WIDTH-1:0] rn_prd_new,
    input  logic                             rn_fire,
    output logic                             rn_ready,
    output logic [RENAME_WIDTH*PREG_WIDTH-1:0] rn_prs1,
    output logic [RENAME_WIDTH*PREG_WIDTH-1:0] rn_prs2,
    output logic [RENAME_WIDTH*PREG_WIDTH-1:0] rn_old_prd,
    input  logic [COMMIT_WIDTH-1:0]          cm_valid,
    input  logic [COMMIT_WIDTH-1:0]          cm_need_to_wb,
    input  logic [COMMIT_WIDTH*LW-1:0]       cm_lrd,
    input  logic [COMMIT_WIDTH*PREG_WIDTH-1:0] cm_prd,
    input  logic                             flush_valid,
    output logic                             restore_busy,
    output logic [LREG_NUM*PREG_WIDTH-1:0]   debug_arch_rat
);

    typedef enum logic {IDLE, RESTORE} state_t;

    localparam logic [LW-1:0] RPC_STEP   = LW'(RESTORE_PER_CYCLE);
    localparam logic [LW-1:0] LAST_CHUNK = LW'(LREG_NUM - RESTORE_PER_CYCLE);

    state_t                  state;
    logic [LW-1:0]           rptr;
    logic [PREG_WIDTH-1:0]   spec_rat [LREG_NUM];
    logic [PREG_WIDTH-1:0]   arch_rat [LREG_NUM];

    // Per-lane unpacked views of the flat rename/commit buses.
    logic [LW-1:0]           lrs1     [RENAME_WIDTH];
    logic [LW-1:0]           lrs2     [RENAME_WIDTH];
    logic [LW-1:0]           lrd      [RENAME_WIDTH];
    logic [PREG_WIDTH-1:0]   prd_new  [RENAME_WIDTH];
    logic [RENAME_WIDTH-1:0] wr;
    logic [LW-1:0]           c_lrd    [COMMIT_WIDTH];
    logic [PREG_WIDTH-1:0]   c_prd    [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0] c_wr;

    logic [PREG_WIDTH-1:0]   rd1      [RENAME_WIDTH];
    logic [PREG_WIDTH-1:0]   rd2      [RENAME_WIDTH];
    logic [PREG_WIDTH-1:0]   rdo      [RENAME_WIDTH];

    logic                    rn_accept;
    logic [LREG_NUM-1:0]     cm_hit;
    logic [LREG_NUM-1:0]     rn_hit;
    logic [LREG_NUM-1:0]     in_chunk;
    logic [LREG_NUM-1:0]     below;
    logic [PREG_WIDTH-1:0]   cm_dat   [LREG_NUM];
    logic [PREG_WIDTH-1:0]   rn_dat   [LREG_NUM];

    assign rn_ready     = (state == IDLE) & ~flush_valid;
    assign restore_busy = (state == RESTORE);
    assign rn_accept    = rn_fire & rn_ready;

    always_comb begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            lrs1[i]    = rn_lrs1[i*LW +: LW];
            lrs2[i]    = rn_lrs2[i*LW +: LW];
            lrd[i]     = rn_lrd[i*LW +: LW];
            prd_new[i] = rn_prd_new[i*PREG_WIDTH +: PREG_WIDTH];
            wr[i]      = rn_valid[i] & rn_need_to_wb[i] & (lrd[i] != '0);
        end
        for (int j = 0; j < COMMIT_WIDTH; j++) begin
            c_lrd[j] = cm_lrd[j*LW +: LW];
            c_prd[j] = cm_prd[j*PREG_WIDTH +: PREG_WIDTH];
            c_wr[j]  = cm_valid[j] & cm_need_to_wb[j] & (c_lrd[j] != '0);
        end
    end

    // Table read, then overridden by each older lane in ascending order so the youngest older writer wins.
    always_comb begin
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            rd1[i] = (lrs1[i] == '0) ? '0 : spec_rat[lrs1[i]];
            rd2[i] = (lrs2[i] == '0) ? '0 : spec_rat[lrs2[i]];
            rdo[i] = (lrd[i]  == '0) ? '0 : spec_rat[lrd[i]];
            for (int j = 0; j < RENAME_WIDTH; j++) begin
                if (j < i && wr[j]) begin
                    if (lrd[j] == lrs1[i]) rd1[i] = prd_new[j];
                    if (lrd[j] == lrs2[i]) rd2[i] = prd_new[j];
                    if (lrd[j] == lrd[i])  rdo[i] = prd_new[j];
                end
            end
        end
    end

    always_comb begin
        rn_prs1    = '0;
        rn_prs2    = '0;
        rn_old_prd = '0;
        for (int i = 0; i < RENAME_WIDTH; i++) begin
            rn_prs1[i*PREG_WIDTH +: PREG_WIDTH]    = rn_src1_is_reg[i] ? rd1[i] : '0;
            rn_prs2[i*PREG_WIDTH +: PREG_WIDTH]    = rn_src2_is_reg[i] ? rd2[i] : '0;
            rn_old_prd[i*PREG_WIDTH +: PREG_WIDTH] = wr[i] ? rdo[i] : '0;
        end
    end

    // Per-entry write decode; later lanes overwrite earlier ones so the highest lane wins a collision.
    always_comb begin
        for (int k = 0; k < LREG_NUM; k++) begin
            cm_hit[k]   = 1'b0;
            cm_dat[k]   = '0;
            rn_hit[k]   = 1'b0;
            rn_dat[k]   = '0;
            in_chunk[k] = (k >= int'(rptr)) && (k < int'(rptr) + RESTORE_PER_CYCLE);
            below[k]    = (k < int'(rptr));
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
                if (c_wr[j] && c_lrd[j] == LW'(k)) begin
                    cm_hit[k] = 1'b1;
                    cm_dat[k] = c_prd[j];
                end
            end
            for (int i = 0; i < RENAME_WIDTH; i++) begin
                if (rn_accept && wr[i] && lrd[i] == LW'(k)) begin
                    rn_hit[k] = 1'b1;
                    rn_dat[k] = prd_new[i];
                end
            end
        end
    end

    always_comb begin
        debug_arch_rat = '0;
        for (int k = 0; k < LREG_NUM; k++) begin
            debug_arch_rat[k*PREG_WIDTH +: PREG_WIDTH] = arch_rat[k];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rptr  <= '0;
            for (int k = 0; k < LREG_NUM; k++) begin
                spec_rat[k] <= PREG_WIDTH'(k);
                arch_rat[k] <= PREG_WIDTH'(k);
            end
        end else begin
            for (int k = 0; k < LREG_NUM; k++) begin
                if (cm_hit[k]) arch_rat[k] <= cm_dat[k];
            end
            if (flush_valid) begin
                state <= RESTORE;
                rptr  <= '0;
            end else if (state == RESTORE) begin
                // Entries already restored must track commits, otherwise they would go stale until the next flush.
                for (int k = 0; k < LREG_NUM; k++) begin
                    if (in_chunk[k])
                        spec_rat[k] <= cm_hit[k] ? cm_dat[k] : arch_rat[k];
                    else if (below[k] && cm_hit[k])
                        spec_rat[k] <= cm_dat[k];
                end
                if (rptr == LAST_CHUNK) begin
                    state <= IDLE;
                    rptr  <= '0;
                end else begin
                    rptr  <= rptr + RPC_STEP;
                end
            end else begin
                for (int k = 0; k < LREG_NUM; k++) begin
                    if (rn_hit[k]) spec_rat[k] <= rn_dat[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_rename_map_table.sv
module tb_rename_map_table;

    localparam int RW = 2;
    localparam int CW = 2;
    localparam int LN = 32;
    localparam int LW = 5;
    localparam int PW = 6;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [RW-1:0]     rn_valid, rn_src1_is_reg, rn_src2_is_reg, rn_need_to_wb;
    logic [RW*LW-1:0]  rn_lrs1, rn_lrs2, rn_lrd;
    logic [RW*PW-1:0]  rn_prd_new;
    logic              rn_fire;
    logic              rn_ready;
    logic [RW*PW-1:0]  rn_prs1, rn_prs2, rn_old_prd;
    logic [CW-1:0]     cm_valid, cm_need_to_wb;
    logic [CW*LW-1:0]  cm_lrd;
    logic [CW*PW-1:0]  cm_prd;
    logic              flush_valid;
    logic              restore_busy;
    logic [LN*PW-1:0]  debug_arch_rat;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int busy_cycles;

    rename_map_table #(
        .RENAME_WIDTH(RW), .COMMIT_WIDTH(CW), .LREG_NUM(LN),
        .PREG_WIDTH(PW), .RESTORE_PER_CYCLE(8)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .rn_valid(rn_valid), .rn_src1_is_reg(rn_src1_is_reg), .rn_src2_is_reg(rn_src2_is_reg),
        .rn_need_to_wb(rn_need_to_wb), .rn_lrs1(rn_lrs1), .rn_lrs2(rn_lrs2), .rn_lrd(rn_lrd),
        .rn_prd_new(rn_prd_new), .rn_fire(rn_fire), .rn_ready(rn_ready),
        .rn_prs1(rn_prs1), .rn_prs2(rn_prs2), .rn_old_prd(rn_old_prd),
        .cm_valid(cm_valid), .cm_need_to_wb(cm_need_to_wb), .cm_lrd(cm_lrd), .cm_prd(cm_prd),
        .flush_valid(flush_valid), .restore_busy(restore_busy), .debug_arch_rat(debug_arch_rat)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rn_valid = '0; rn_src1_is_reg = '0; rn_src2_is_reg = '0; rn_need_to_wb = '0;
        rn_lrs1 = '0; rn_lrs2 = '0; rn_lrd = '0; rn_prd_new = '0; rn_fire = 1'b0;
        cm_valid = '0; cm_need_to_wb = '0; cm_lrd = '0; cm_prd = '0; flush_valid = 1'b0;
    endtask

    task automatic lane(input int i, input logic s1, input int l1, input logic s2, input int l2,
                        input logic wb, input int ld, input int prd);
        rn_valid[i] = 1'b1; rn_src1_is_reg[i] = s1; rn_src2_is_reg[i] = s2; rn_need_to_wb[i] = wb;
        rn_lrs1[i*LW +: LW] = LW'(l1); rn_lrs2[i*LW +: LW] = LW'(l2);
        rn_lrd[i*LW +: LW] = LW'(ld); rn_prd_new[i*PW +: PW] = PW'(prd);
    endtask

    task automatic cmt(input int j, input int ld, input int prd);
        cm_valid[j] = 1'b1; cm_need_to_wb[j] = 1'b1;
        cm_lrd[j*LW +: LW] = LW'(ld); cm_prd[j*PW +: PW] = PW'(prd);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reads one speculative entry through lane 0 in an otherwise idle cycle.
    task automatic chk_spec(input string tag, input int k, input int exp);
        idle();
        rn_src1_is_reg[0] = 1'b1;
        rn_lrs1[0 +: LW] = LW'(k);
        #1;
        chk(tag, 32'(rn_prs1[0 +: PW]), exp);
        tick();
    endtask

    task automatic chk_arch(input string tag, input int k, input int exp);
        chk(tag, 32'(debug_arch_rat[k*PW +: PW]), exp);
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        #12;
        reset_n = 1'b1;
        #1;
        chk("reset_ready", 32'(rn_ready), 1);
        chk("reset_busy", 32'(restore_busy), 0);
        for (int k = 0; k < LN; k++) chk_arch($sformatf("reset_arch%0d", k), k, k);
        tick();
        chk_spec("reset_spec5", 5, 5);

        // Intra-group bypass on both source and old mapping.
        idle();
        lane(0, 1'b0, 0, 1'b0, 0, 1'b1, 3, 40);
        lane(1, 1'b1, 3, 1'b0, 0, 1'b1, 3, 41);
        rn_fire = 1'b1;
        #1;
        chk("byp_l1_prs1", 32'(rn_prs1[PW +: PW]), 40);
        chk("byp_l0_prs1_noreg", 32'(rn_prs1[0 +: PW]), 0);
        chk("byp_l0_old", 32'(rn_old_prd[0 +: PW]), 3);
        chk("byp_l1_old", 32'(rn_old_prd[PW +: PW]), 40);
        tick();
        chk_spec("byp_spec3", 3, 41);

        // x0: no write, no bypass, reads and old mapping are zero.
        idle();
        lane(0, 1'b0, 0, 1'b0, 0, 1'b1, 0, 50);
        lane(1, 1'b1, 0, 1'b1, 0, 1'b1, 0, 51);
        rn_fire = 1'b1;
        #1;
        chk("x0_l1_prs1", 32'(rn_prs1[PW +: PW]), 0);
        chk("x0_l1_prs2", 32'(rn_prs2[PW +: PW]), 0);
        chk("x0_l0_old", 32'(rn_old_prd[0 +: PW]), 0);
        chk("x0_l1_old", 32'(rn_old_prd[PW +: PW]), 0);
        tick();
        chk_spec("x0_spec0", 0, 0);

        // Lane without need_to_wb neither bypasses nor reports an old mapping.
        idle();
        lane(0, 1'b0, 0, 1'b0, 0, 1'b0, 3, 52);
        lane(1, 1'b1, 3, 1'b1, 9, 1'b0, 0, 0);
        #1;
        chk("nowb_l0_old", 32'(rn_old_prd[0 +: PW]), 0);
        chk("nowb_l1_prs1", 32'(rn_prs1[PW +: PW]), 41);
        chk("nowb_l1_prs2", 32'(rn_prs2[PW +: PW]), 9);
        tick();

        // Commit collision: highest lane wins; spec table untouched while idle.
        idle();
        cmt(0, 7, 20);
        cmt(1, 7, 21);
        tick();
        chk_arch("cm_coll_arch7", 7, 21);
        chk_spec("cm_coll_spec7", 7, 7);

        // Flush restore with commits and a blocked rename along the way.
        idle();
        lane(0, 1'b0, 0, 1'b0, 0, 1'b1, 1, 33);
        lane(1, 1'b0, 0, 1'b0, 0, 1'b1, 9, 34);
        rn_fire = 1'b1;
        tick();
        chk_spec("pre_spec1", 1, 33);
        chk_spec("pre_spec9", 9, 34);
        idle();
        cmt(0, 1, 33);
        tick();
        idle();
        flush_valid = 1'b1;
        lane(0, 1'b0, 0, 1'b0, 0, 1'b1, 4, 44);
        rn_fire = 1'b1;
        #1;
        chk("fl_ready", 32'(rn_ready), 0);
        chk("fl_busy", 32'(restore_busy), 0);
        tick();
        idle();
        cmt(0, 2, 60);
        #1;
        chk("r1_ready", 32'(rn_ready), 0);
        chk("r1_busy", 32'(restore_busy), 1);
        tick();
        idle();
        lane(0, 1'b0, 0, 1'b0, 0, 1'b1, 5, 55);
        rn_fire = 1'b1;
        #1;
        chk("r2_ready", 32'(rn_ready), 0);
        chk("r2_busy", 32'(restore_busy), 1);
        tick();
        idle();
        cmt(0, 3, 62);
        cmt(1, 30, 63);
        #1;
        chk("r3_ready", 32'(rn_ready), 0);
        chk("r3_busy", 32'(restore_busy), 1);
        tick();
        idle();
        #1;
        chk("r4_ready", 32'(rn_ready), 0);
        chk("r4_busy", 32'(restore_busy), 1);
        tick();
        idle();
        #1;
        chk("post_ready", 32'(rn_ready), 1);
        chk("post_busy", 32'(restore_busy), 0);
        chk_arch("post_arch2", 2, 60);
        chk_spec("post_spec1", 1, 33);
        chk_spec("post_spec9", 9, 9);
        chk_spec("post_spec2", 2, 60);
        chk_spec("post_spec4", 4, 4);
        chk_spec("post_spec5", 5, 5);
        chk_spec("post_spec3", 3, 62);
        chk_spec("post_spec30", 30, 63);
        chk_spec("post_spec7", 7, 21);

        // Flush in the third restore cycle restarts the walk.
        idle();
        lane(0, 1'b0, 0, 1'b0, 0, 1'b1, 6, 45);
        rn_fire = 1'b1;
        tick();
        chk_spec("rs_pre_spec6", 6, 45);
        idle();
        flush_valid = 1'b1;
        #1;
        tick();
        busy_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            idle();
            if (c == 2) flush_valid = 1'b1;
            #1;
            if (!restore_busy) break;
            busy_cycles++;
            tick();
        end
        chk("rs_busy_cycles", 32'(busy_cycles), 7);
        chk("rs_ready", 32'(rn_ready), 1);
        chk_spec("rs_spec6", 6, 6);

        // Reset in the middle of a restore.
        idle();
        lane(0, 1'b0, 0, 1'b0, 0, 1'b1, 8, 46);
        rn_fire = 1'b1;
        cmt(0, 8, 47);
        tick();
        idle();
        flush_valid = 1'b1;
        #1;
        tick();
        idle();
        #1;
        tick();
        chk("mr_busy_before", 32'(restore_busy), 1);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
        chk("mr_ready", 32'(rn_ready), 1);
        chk("mr_busy", 32'(restore_busy), 0);
        chk_arch("mr_arch8", 8, 8);
        chk_arch("mr_arch2", 2, 2);
        chk_arch("mr_arch7", 7, 7);
        tick();
        chk_spec("mr_spec8", 8, 8);
        chk_spec("mr_spec1", 1, 1);
        chk_spec("mr_spec3", 3, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
